// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - two-requester round-robin front end for a shared combinational ALU
//
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   reqN_valid/reqN_ready           per-requester op handshake (N = 0, 1)
//   reqN_a, reqN_b, reqN_op         per-requester operands and control code
//   alu_a, alu_b, alu_control       registered operands/control driven to the ALU
//   alu_out, alu_carry              combinational ALU result returned to this block
//   rsp_valid/rsp_ready             response handshake
//   rsp_id, rsp_data, rsp_carry     issuing requester and captured result
//   grant_cnt0, grant_cnt1          saturating accept counters (only with ALU_ARBITER_STATS_EN)
//
// Optional feature macro: ALU_ARBITER_STATS_EN
module alu_arbiter #(
    parameter int WIDTH = 64,
    parameter int OPW   = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [OPW-1:0]   req0_op,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [OPW-1:0]   req1_op,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [OPW-1:0]   alu_control,
    input  logic [WIDTH-1:0] alu_out,
    input  logic             alu_carry,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_data,
    output logic             rsp_carry
`ifdef ALU_ARBITER_STATS_EN
    ,
    output logic [15:0]      grant_cnt0,
    output logic [15:0]      grant_cnt1
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t           state_q;
    logic             last_q;
    logic             id_q;
    logic [WIDTH-1:0] alu_a_q;
    logic [WIDTH-1:0] alu_b_q;
    logic [OPW-1:0]   alu_control_q;
    logic             rsp_valid_q;
    logic             rsp_id_q;
    logic [WIDTH-1:0] rsp_data_q;
    logic             rsp_carry_q;

    logic             grant_d;
    logic             idle;
    logic             accept;

    // Contention goes to whoever was not served last; otherwise the lone
    // valid requester wins (grant_d is don't-care when nobody is valid).
    assign grant_d    = (req0_valid && req1_valid) ? ~last_q : req1_valid;
    assign idle       = (state_q == IDLE);
    assign req0_ready = idle && req0_valid && !grant_d;
    assign req1_ready = idle && req1_valid && grant_d;
    assign accept     = req0_ready || req1_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            last_q        <= 1'b1;
            id_q          <= 1'b0;
            alu_a_q       <= '0;
            alu_b_q       <= '0;
            alu_control_q <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_id_q      <= 1'b0;
            rsp_data_q    <= '0;
            rsp_carry_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        alu_a_q       <= grant_d ? req1_a  : req0_a;
                        alu_b_q       <= grant_d ? req1_b  : req0_b;
                        alu_control_q <= grant_d ? req1_op : req0_op;
                        id_q          <= grant_d;
                        last_q        <= grant_d;
                        state_q       <= EXEC;
                    end
                end
                EXEC: begin
                    // The ALU has had one full cycle on the registered operands.
                    rsp_data_q  <= alu_out;
                    rsp_carry_q <= alu_carry;
                    rsp_id_q    <= id_q;
                    rsp_valid_q <= 1'b1;
                    state_q     <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    rsp_valid_q <= 1'b0;
                end
            endcase
        end
    end

`ifdef ALU_ARBITER_STATS_EN
    logic [15:0] cnt0_q;
    logic [15:0] cnt1_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt0_q <= '0;
            cnt1_q <= '0;
        end else begin
            if (req0_ready && cnt0_q != 16'hFFFF) begin
                cnt0_q <= cnt0_q + 16'd1;
            end
            if (req1_ready && cnt1_q != 16'hFFFF) begin
                cnt1_q <= cnt1_q + 16'd1;
            end
        end
    end

    assign grant_cnt0 = cnt0_q;
    assign grant_cnt1 = cnt1_q;
`endif

    assign alu_a       = alu_a_q;
    assign alu_b       = alu_b_q;
    assign alu_control = alu_control_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_id      = rsp_id_q;
    assign rsp_data    = rsp_data_q;
    assign rsp_carry   = rsp_carry_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - directed scoreboard bench for alu_arbiter
module tb_alu_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0_valid, req1_valid;
    logic        req0_ready, req1_ready;
    logic [63:0] req0_a, req0_b, req1_a, req1_b;
    logic [3:0]  req0_op, req1_op;
    logic [63:0] alu_a, alu_b, alu_out;
    logic [3:0]  alu_control;
    logic        alu_carry;
    logic        rsp_valid, rsp_ready, rsp_id, rsp_carry;
    logic [63:0] rsp_data;
`ifdef ALU_ARBITER_STATS_EN
    logic [15:0] grant_cnt0, grant_cnt1;
`endif

    int total = 0;
    int bad   = 0;
    int cnt0_exp = 0;
    int cnt1_exp = 0;

    typedef struct {
        logic        id;
        logic [63:0] data;
        logic        carry;
    } exp_t;

    exp_t exp_q[$];
    exp_t last_e;

    always #5 clk = ~clk;

    function automatic logic [64:0] alu_model(input logic [63:0] a, input logic [63:0] b,
                                              input logic [3:0] op);
        logic [64:0] r;
        case (op)
            4'h0:    r = {1'b0, a} + {1'b0, b};
            4'h1:    r = {1'b0, a} - {1'b0, b};
            4'h2:    r = {1'b0, a & b};
            4'h3:    r = {1'b0, a | b};
            4'h4:    r = {1'b0, a ^ b};
            4'hC:    r = {1'b0, a << b[5:0]};
            default: r = {1'b0, ~a};
        endcase
        return r;
    endfunction

    logic [64:0] alu_res;
    assign alu_res   = alu_model(alu_a, alu_b, alu_control);
    assign alu_out   = alu_res[63:0];
    assign alu_carry = alu_res[64];

    alu_arbiter #(.WIDTH(64), .OPW(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
        .alu_a(alu_a), .alu_b(alu_b), .alu_control(alu_control),
        .alu_out(alu_out), .alu_carry(alu_carry),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_carry(rsp_carry)
`ifdef ALU_ARBITER_STATS_EN
        , .grant_cnt0(grant_cnt0), .grant_cnt1(grant_cnt1)
`endif
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input logic id, input logic [63:0] a, input logic [63:0] b,
                            input logic [3:0] op);
        exp_t e;
        logic [64:0] r;
        r = alu_model(a, b, op);
        e.id = id;
        e.data = r[63:0];
        e.carry = r[64];
        exp_q.push_back(e);
        if (id) cnt1_exp++;
        else    cnt0_exp++;
    endtask

    task automatic pop_chk(input string tag);
        if (exp_q.size() == 0) begin
            chk({tag, "_sb_empty"}, 64'd1, 64'd0);
        end else begin
            last_e = exp_q.pop_front();
            chk({tag, "_id"},    {63'd0, rsp_id},    {63'd0, last_e.id});
            chk({tag, "_data"},  rsp_data,           last_e.data);
            chk({tag, "_carry"}, {63'd0, rsp_carry}, {63'd0, last_e.carry});
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_rsp_valid"}, {63'd0, rsp_valid}, 64'd0);
        chk({tag, "_rsp_id"},    {63'd0, rsp_id},    64'd0);
        chk({tag, "_rsp_data"},  rsp_data,           64'd0);
        chk({tag, "_rsp_carry"}, {63'd0, rsp_carry}, 64'd0);
        chk({tag, "_alu_a"},     alu_a,              64'd0);
        chk({tag, "_alu_b"},     alu_b,              64'd0);
        chk({tag, "_alu_ctl"},   {60'd0, alu_control}, 64'd0);
        chk({tag, "_ready0"},    {63'd0, req0_ready}, 64'd0);
        chk({tag, "_ready1"},    {63'd0, req1_ready}, 64'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [63:0] a0, b0, a1, b1, ea, eb;
        logic [3:0]  op0, op1, eop;
        logic        gid;

        rst_n = 1'b0;
        req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b0;
        req0_a = '0; req0_b = '0; req0_op = '0;
        req1_a = '0; req1_b = '0; req1_op = '0;

        repeat (2) @(negedge clk);
        #1;
        chk_all_zero("reset");

        // Single op from req0, accepted on the first edge after reset release.
        @(negedge clk);
        rst_n = 1'b1;
        req0_valid = 1'b1; req0_a = 64'hD; req0_b = 64'h1; req0_op = 4'hC;
        #1;
        chk("single_ready0", {63'd0, req0_ready}, 64'd1);
        chk("single_ready1", {63'd0, req1_ready}, 64'd0);
        push_exp(1'b0, 64'hD, 64'h1, 4'hC);

        // EXEC: operands latched; new requester values must not leak in.
        @(negedge clk);
        req0_a = 64'hFFFF_0000_FFFF_0000; req0_op = 4'h1;
        req1_valid = 1'b1; req1_a = 64'h8000_0000_0000_0001; req1_b = 64'h8000_0000_0000_0003;
        req1_op = 4'h0;
        #1;
        chk("exec_alu_a",   alu_a, 64'hD);
        chk("exec_alu_b",   alu_b, 64'h1);
        chk("exec_alu_ctl", {60'd0, alu_control}, 64'hC);
        chk("exec_rsp_valid", {63'd0, rsp_valid}, 64'd0);
        chk("exec_ready0", {63'd0, req0_ready}, 64'd0);
        chk("exec_ready1", {63'd0, req1_ready}, 64'd0);

        @(negedge clk);
        #1;
        chk("single_rsp_valid", {63'd0, rsp_valid}, 64'd1);
        pop_chk("single");

        // Backpressure: response held stable, no grants, for five cycles.
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            #1;
            chk("bp_rsp_valid", {63'd0, rsp_valid}, 64'd1);
            chk("bp_rsp_data",  rsp_data, last_e.data);
            chk("bp_rsp_id",    {63'd0, rsp_id}, {63'd0, last_e.id});
            chk("bp_ready0",    {63'd0, req0_ready}, 64'd0);
            chk("bp_ready1",    {63'd0, req1_ready}, 64'd0);
        end
        @(negedge clk);
        rsp_ready = 1'b1;
        #1;
        chk("bp_release_valid", {63'd0, rsp_valid}, 64'd1);

        // Back in IDLE; req0 was served last, so contention goes to req1.
        @(negedge clk);
        rsp_ready = 1'b0;
        #1;
        chk("idle_rsp_valid", {63'd0, rsp_valid}, 64'd0);
        chk("rr_ready0", {63'd0, req0_ready}, 64'd0);
        chk("rr_ready1", {63'd0, req1_ready}, 64'd1);
        push_exp(1'b1, req1_a, req1_b, req1_op);

        // Reset while in EXEC abandons the op.
        @(negedge clk);
        req0_valid = 1'b0; req1_valid = 1'b0;
        #1;
        chk("rst_exec_alu_a", alu_a, 64'h8000_0000_0000_0001);
        rst_n = 1'b0;
        #1;
        chk_all_zero("rst_mid");
        exp_q.delete();
        cnt0_exp = 0;
        cnt1_exp = 0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            #1;
            chk("post_rst_no_rsp", {63'd0, rsp_valid}, 64'd0);
        end

        // Contention with rsp_ready high: grants 0,1,0,1, one accept per 3 cycles.
        rsp_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            a0 = {$urandom, $urandom}; b0 = {$urandom, $urandom};
            a1 = {$urandom, $urandom}; b1 = {$urandom, $urandom};
            op0 = 4'(i);
            op1 = 4'(3 + i);
            req0_valid = 1'b1; req0_a = a0; req0_b = b0; req0_op = op0;
            req1_valid = 1'b1; req1_a = a1; req1_b = b1; req1_op = op1;
            gid = i[0];
            ea  = gid ? a1 : a0;
            eb  = gid ? b1 : b0;
            eop = gid ? op1 : op0;
            #1;
            chk("cont_ready0", {63'd0, req0_ready}, {63'd0, ~gid});
            chk("cont_ready1", {63'd0, req1_ready}, {63'd0, gid});
            push_exp(gid, ea, eb, eop);
            @(negedge clk);
            #1;
            chk("cont_alu_a", alu_a, ea);
            chk("cont_alu_b", alu_b, eb);
            chk("cont_alu_ctl", {60'd0, alu_control}, {60'd0, eop});
            chk("cont_exec_valid", {63'd0, rsp_valid}, 64'd0);
            @(negedge clk);
            #1;
            chk("cont_rsp_valid", {63'd0, rsp_valid}, 64'd1);
            pop_chk("cont");
        end

        // Lone requester: req1 alone is granted even though it was served last.
        @(negedge clk);
        req0_valid = 1'b0;
        req1_a = 64'hFFFF_FFFF_FFFF_FFFF; req1_b = 64'h1; req1_op = 4'h0;
        #1;
        chk("lone_ready0", {63'd0, req0_ready}, 64'd0);
        chk("lone_ready1", {63'd0, req1_ready}, 64'd1);
        push_exp(1'b1, req1_a, req1_b, req1_op);
        @(negedge clk);
        req1_valid = 1'b0;
        @(negedge clk);
        #1;
        chk("lone_rsp_valid", {63'd0, rsp_valid}, 64'd1);
        pop_chk("lone");
        @(negedge clk);
        #1;
        chk("final_idle_valid", {63'd0, rsp_valid}, 64'd0);
        chk("final_sb_empty", 64'(exp_q.size()), 64'd0);

`ifdef ALU_ARBITER_STATS_EN
        chk("stats_cnt0", {48'd0, grant_cnt0}, 64'(cnt0_exp));
        chk("stats_cnt1", {48'd0, grant_cnt1}, 64'(cnt1_exp));
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
